// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared pipeline definitions: writeback source encodings, the generic stage-register
// entry layout and the occupancy-keyed state encoding of the MEM->WB skid register.
package pipe_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_IMM  = 2'b10;
   localparam logic [1:0] WB_SEL_ZERO = 2'b11;

   localparam int PIPE_DATA_W  = 8;
   localparam int PIPE_RADDR_W = 3;

   // Default-width stage entry; 'rd' is the destination register index.
   typedef struct packed {
      logic                    valid;
      logic [PIPE_DATA_W-1:0]  data;
      logic [PIPE_RADDR_W-1:0] rd;
      logic                    we;
   } wb_entry_t;

   // State value equals the number of held entries, so it doubles as occupancy.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

endpackage

// File: rtl/mem_wb_skid_reg_if.sv
// MEM->WB boundary bundle: upstream entry handshake plus the writeback/forwarding view.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid and payload must be held until then, and ready never depends on same-cycle valid.
interface mem_wb_skid_reg_if #(
   parameter int DATA_W  = 8,
   parameter int RADDR_W = 3
) ();

   logic               in_valid_i;
   logic               in_ready_o;
   logic [DATA_W-1:0]  alu_result_i;
   logic [DATA_W-1:0]  mem_data_i;
   logic [DATA_W-1:0]  immed_i;
   logic [1:0]         wb_sel_i;
   logic [RADDR_W-1:0] target_reg_i;
   logic               reg_write_i;

   logic               out_valid_o;
   logic               out_ready_i;
   logic [DATA_W-1:0]  wb_data_o;
   logic [RADDR_W-1:0] target_reg_o;
   logic               reg_write_o;

   logic               fwd_valid_o;
   logic [RADDR_W-1:0] fwd_reg_o;
   logic [DATA_W-1:0]  fwd_data_o;

   modport slave (
      input  in_valid_i, alu_result_i, mem_data_i, immed_i, wb_sel_i,
             target_reg_i, reg_write_i, out_ready_i,
      output in_ready_o, out_valid_o, wb_data_o, target_reg_o, reg_write_o,
             fwd_valid_o, fwd_reg_o, fwd_data_o
   );

   modport master (
      output in_valid_i, alu_result_i, mem_data_i, immed_i, wb_sel_i,
             target_reg_i, reg_write_i, out_ready_i,
      input  in_ready_o, out_valid_o, wb_data_o, target_reg_o, reg_write_o,
             fwd_valid_o, fwd_reg_o, fwd_data_o
   );

endinterface

// File: rtl/mem_wb_skid_reg_wb_src_mux.sv
// Combinational 4:1 writeback source select (ALU / memory / immediate / zero).
module wb_src_mux
   import pipe_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [1:0]        sel_i,
   input  logic [DATA_W-1:0] alu_i,
   input  logic [DATA_W-1:0] mem_i,
   input  logic [DATA_W-1:0] imm_i,
   output logic [DATA_W-1:0] data_o
);

   always_comb begin
      data_o = '0;
      case (sel_i)
         WB_SEL_ALU:  data_o = alu_i;
         WB_SEL_MEM:  data_o = mem_i;
         WB_SEL_IMM:  data_o = imm_i;
         WB_SEL_ZERO: data_o = '0;
         default:     data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB stage register with a 2-entry skid buffer (head H, skid S). Ready comes only
// from registered state, so WB stalls never form a combinational path back into MEM.
module mem_wb_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int RADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   mem_wb_skid_reg_if.slave  bus,
   output logic [1:0]        occupancy_o
);

   typedef struct packed {
      logic               valid;
      logic [DATA_W-1:0]  data;
      logic [RADDR_W-1:0] rd;
      logic               we;
   } entry_t;

   occ_state_e        state_q, state_d;
   entry_t            h_q, h_d;
   entry_t            s_q, s_d;
   entry_t            in_entry;
   logic [DATA_W-1:0] sel_data;
   logic              accept;
   logic              pop;

   wb_src_mux #(.DATA_W(DATA_W)) u_src_mux (
      .sel_i  (bus.wb_sel_i),
      .alu_i  (bus.alu_result_i),
      .mem_i  (bus.mem_data_i),
      .imm_i  (bus.immed_i),
      .data_o (sel_data)
   );

   assign in_entry = '{valid: 1'b1, data: sel_data, rd: bus.target_reg_i, we: bus.reg_write_i};

   assign accept = bus.in_valid_i & bus.in_ready_o;
   assign pop    = bus.out_valid_o & bus.out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCC_EMPTY;
         h_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         s_q     <= s_d;
      end
   end

   // Vacated slots are always written back to zero so idle outputs read 0.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      s_d     = s_q;
      if (flush_i) begin
         state_d = OCC_EMPTY;
         h_d     = '0;
         s_d     = '0;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  state_d = OCC_ONE;
                  h_d     = in_entry;
               end
            end
            OCC_ONE: begin
               if (accept && pop) begin
                  h_d = in_entry;
               end else if (accept) begin
                  state_d = OCC_TWO;
                  s_d     = in_entry;
               end else if (pop) begin
                  state_d = OCC_EMPTY;
                  h_d     = '0;
               end
            end
            OCC_TWO: begin
               if (pop) begin
                  state_d = OCC_ONE;
                  h_d     = s_q;
                  s_d     = '0;
               end
            end
            default: begin
               state_d = OCC_EMPTY;
               h_d     = '0;
               s_d     = '0;
            end
         endcase
      end
   end

   assign bus.in_ready_o   = ~s_q.valid;
   assign bus.out_valid_o  = h_q.valid;
   assign bus.wb_data_o    = h_q.data;
   assign bus.target_reg_o = h_q.rd;
   assign bus.reg_write_o  = h_q.valid & h_q.we;

   assign bus.fwd_valid_o  = bus.reg_write_o;
   assign bus.fwd_reg_o    = h_q.rd;
   assign bus.fwd_data_o   = h_q.data;

   assign occupancy_o      = state_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: scoreboard queue filled on accepted inputs,
// drained by a negedge monitor on every WB pop, plus direct status checks.
module tb_mem_wb_skid_reg;

   localparam int DW = 8;
   localparam int RW = 3;
   localparam int EW = DW + RW + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic [1:0]    occupancy;
   logic [DW-1:0] exp_data;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];

   mem_wb_skid_reg_if #(.DATA_W(DW), .RADDR_W(RW)) bus ();

   mem_wb_skid_reg #(.DATA_W(DW), .RADDR_W(RW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .bus         (bus),
      .occupancy_o (occupancy)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mem, input logic [DW-1:0] imm,
                        input logic [RW-1:0] rd, input logic we, input logic [DW-1:0] exp_d);
      bus.in_valid_i   = v;
      bus.wb_sel_i     = sel;
      bus.alu_result_i = alu;
      bus.mem_data_i   = mem;
      bus.immed_i      = imm;
      bus.target_reg_i = rd;
      bus.reg_write_i  = we;
      exp_data         = exp_d;
   endtask

   task automatic idle_garbage();
      drive(1'b0, 2'b10, 8'hDE, 8'hAD, 8'hBE, 3'd7, 1'b1, 8'hEE);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
      check({tag, "_reg_write"}, 32'(bus.reg_write_o), 32'd0);
      check({tag, "_fwd_valid"}, 32'(bus.fwd_valid_o), 32'd0);
      check({tag, "_wb_data"},   32'(bus.wb_data_o),   32'd0);
      check({tag, "_target"},    32'(bus.target_reg_o), 32'd0);
      check({tag, "_occ"},       32'(occupancy),       32'd0);
      check({tag, "_in_ready"},  32'(bus.in_ready_o),  32'd1);
   endtask

   // scoreboard monitor: decisions for the next rising edge, taken on the falling edge
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n) begin
         if (flush) begin
            exp_q.delete();
         end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: got data %0h expected no output", bus.wb_data_o);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_data",      32'(bus.wb_data_o),    32'(e[EW-1 -: DW]));
                  check("sb_target",    32'(bus.target_reg_o), 32'(e[RW:1]));
                  check("sb_reg_write", 32'(bus.reg_write_o),  32'(e[0]));
                  check("sb_fwd_valid", 32'(bus.fwd_valid_o),  32'(e[0]));
                  check("sb_fwd_reg",   32'(bus.fwd_reg_o),    32'(e[RW:1]));
                  check("sb_fwd_data",  32'(bus.fwd_data_o),   32'(e[EW-1 -: DW]));
               end
            end
            if (bus.in_valid_i && bus.in_ready_o)
               exp_q.push_back({exp_data, bus.target_reg_i, bus.reg_write_i});
         end
      end
   end

   always @(negedge rst_n) exp_q.delete();

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      bus.out_ready_i = 1'b0;
      idle_garbage();
      #3;
      check_idle("reset");
      rst_n = 1'b1;
      cyc();

      // 1: single ALU entry, continuous streaming
      bus.out_ready_i = 1'b1;
      drive(1'b1, 2'b00, 8'h3C, 8'h12, 8'h34, 3'd3, 1'b1, 8'h3C);
      cyc();
      check("s1_out_valid", 32'(bus.out_valid_o), 32'd1);
      check("s1_wb_data",   32'(bus.wb_data_o),   32'h3C);
      check("s1_target",    32'(bus.target_reg_o), 32'd3);
      check("s1_reg_write", 32'(bus.reg_write_o), 32'd1);
      check("s1_fwd_valid", 32'(bus.fwd_valid_o), 32'd1);
      check("s1_occ",       32'(occupancy),       32'd1);

      // 2: memory, immediate, zero sources back to back
      drive(1'b1, 2'b01, 8'h99, 8'hA5, 8'h55, 3'd1, 1'b1, 8'hA5);
      cyc();
      check("s2_mem", 32'(bus.wb_data_o), 32'hA5);
      check("s2_occ", 32'(occupancy),     32'd1);
      drive(1'b1, 2'b10, 8'h99, 8'h66, 8'h7F, 3'd2, 1'b1, 8'h7F);
      cyc();
      check("s2_imm", 32'(bus.wb_data_o), 32'h7F);
      drive(1'b1, 2'b11, 8'hC3, 8'h5A, 8'hF0, 3'd4, 1'b1, 8'h00);
      cyc();
      check("s2_zero",       32'(bus.wb_data_o),   32'h00);
      check("s2_zero_valid", 32'(bus.out_valid_o), 32'd1);
      check("s2_zero_occ",   32'(occupancy),       32'd1);
      idle_garbage();
      cyc();
      check_idle("s2_drain");

      // 3: WB stall fills the skid slot; third input must wait
      bus.out_ready_i = 1'b0;
      drive(1'b1, 2'b00, 8'h11, 8'h00, 8'h00, 3'd1, 1'b1, 8'h11);
      cyc();
      check("s3_occ1",   32'(occupancy),      32'd1);
      check("s3_ready1", 32'(bus.in_ready_o), 32'd1);
      drive(1'b1, 2'b01, 8'h00, 8'h22, 8'h00, 3'd2, 1'b1, 8'h22);
      cyc();
      check("s3_occ2",   32'(occupancy),      32'd2);
      check("s3_ready2", 32'(bus.in_ready_o), 32'd0);
      drive(1'b1, 2'b00, 8'h33, 8'h00, 8'h00, 3'd3, 1'b1, 8'h33);
      cyc();
      check("s3_hold_occ",  32'(occupancy),     32'd2);
      check("s3_hold_head", 32'(bus.wb_data_o), 32'h11);
      idle_garbage();
      bus.out_ready_i = 1'b1;
      cyc();
      check("s3_second",   32'(bus.wb_data_o),  32'h22);
      check("s3_occ_pop",  32'(occupancy),      32'd1);
      check("s3_ready_rt", 32'(bus.in_ready_o), 32'd1);
      cyc();
      check_idle("s3_drain");

      // 4: flush with two held entries and a valid input
      bus.out_ready_i = 1'b0;
      drive(1'b1, 2'b00, 8'h44, 8'h00, 8'h00, 3'd4, 1'b1, 8'h44);
      cyc();
      drive(1'b1, 2'b00, 8'h55, 8'h00, 8'h00, 3'd5, 1'b1, 8'h55);
      cyc();
      check("s4_occ2", 32'(occupancy), 32'd2);
      flush = 1'b1;
      drive(1'b1, 2'b00, 8'h66, 8'h00, 8'h00, 3'd6, 1'b1, 8'h66);
      cyc();
      check_idle("s4_flush2");
      // flush with one entry while the input is acceptable
      flush = 1'b0;
      drive(1'b1, 2'b00, 8'h67, 8'h00, 8'h00, 3'd6, 1'b1, 8'h67);
      cyc();
      check("s4_occ1", 32'(occupancy), 32'd1);
      flush = 1'b1;
      drive(1'b1, 2'b00, 8'h68, 8'h00, 8'h00, 3'd6, 1'b1, 8'h68);
      cyc();
      check_idle("s4_flush1");
      flush = 1'b0;
      idle_garbage();
      bus.out_ready_i = 1'b1;
      cyc();
      check_idle("s4_after");

      // 5: non-writing entry
      drive(1'b1, 2'b00, 8'hFF, 8'h00, 8'h00, 3'd5, 1'b0, 8'hFF);
      cyc();
      check("s5_out_valid", 32'(bus.out_valid_o), 32'd1);
      check("s5_reg_write", 32'(bus.reg_write_o), 32'd0);
      check("s5_fwd_valid", 32'(bus.fwd_valid_o), 32'd0);
      check("s5_wb_data",   32'(bus.wb_data_o),   32'hFF);
      idle_garbage();
      cyc();
      check_idle("s5_drain");

      // 6: asynchronous reset with two held entries
      bus.out_ready_i = 1'b0;
      drive(1'b1, 2'b00, 8'h77, 8'h00, 8'h00, 3'd1, 1'b1, 8'h77);
      cyc();
      drive(1'b1, 2'b00, 8'h88, 8'h00, 8'h00, 3'd2, 1'b1, 8'h88);
      cyc();
      check("s6_occ2", 32'(occupancy), 32'd2);
      idle_garbage();
      rst_n = 1'b0;
      #1;
      check_idle("s6_async");
      #1;
      rst_n = 1'b1;
      bus.out_ready_i = 1'b1;
      drive(1'b1, 2'b00, 8'h3C, 8'h12, 8'h34, 3'd3, 1'b1, 8'h3C);
      cyc();
      check("s6_out_valid", 32'(bus.out_valid_o), 32'd1);
      check("s6_wb_data",   32'(bus.wb_data_o),   32'h3C);
      check("s6_target",    32'(bus.target_reg_o), 32'd3);
      check("s6_reg_write", 32'(bus.reg_write_o), 32'd1);
      check("s6_occ",       32'(occupancy),       32'd1);
      idle_garbage();
      cyc();
      cyc();
      check_idle("s6_drain");
      check("sb_leftover", 32'(exp_q.size()), 32'd0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Parametrised MEM->WB pipeline boundary with a valid/ready handshake and a 2-entry skid buffer, so the writeback side can stall without a combinational ready path back into MEM.
- Selects the writeback value (ALU / memory / immediate) before registering, and presents one result word plus destination and write-enable.
- Exposes the head entry as a forwarding source.
- Synchronous flush replaces the old jump-clear behaviour.

Parameters:
- DATA_W, 8, datapath width of ALU result, memory data, immediate and writeback data.
- RADDR_W, 3, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all held and incoming entries.
- in_valid_i  in  1  MEM stage presents an entry.
- in_ready_o  in/out: out  1  stage can accept an entry this cycle.
- alu_result_i  in  DATA_W  ALU result.
- mem_data_i  in  DATA_W  data-memory read data.
- immed_i  in  DATA_W  immediate.
- wb_sel_i  in  2  writeback source: 00 ALU, 01 mem, 10 immed, 11 zero.
- target_reg_i  in  RADDR_W  destination register.
- reg_write_i  in  1  entry writes the register file.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  WB consumes the head this cycle.
- wb_data_o  out  DATA_W  head writeback data.
- target_reg_o  out  RADDR_W  head destination.
- reg_write_o  out  1  out_valid_o AND head reg_write.
- fwd_valid_o  out  1  equals reg_write_o.
- fwd_reg_o  out  RADDR_W  equals target_reg_o.
- fwd_data_o  out  DATA_W  equals wb_data_o.
- occupancy_o  out  2  entries held (0..2).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all registers cleared, so out_valid_o=0, reg_write_o=0, wb_data_o=0, target_reg_o=0, occupancy_o=0, in_ready_o=1. Reset asserted mid-transfer discards everything immediately.
- Storage: head register H and skid register S, each holding {valid, data, reg, we}.
- Select mux: combinational on input, sel_data = wb_sel_i ? {alu, mem, immed, 0}. Only the selected word is stored.
- Ready: in_ready_o = !S.valid, registered state only; no combinational dependence on out_ready_i.
- Transfer rules: accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i. out_valid_o = H.valid.
- State machine, keyed on occupancy (listed in priority order after reset):
  - flush_i=1, any state: next state EMPTY; H and S cleared to all-zero; an accept in the same cycle is dropped; in_ready_o=1 next cycle.
  - EMPTY (0): accept -> ONE, H <= input; latency 1 cycle from accept to out_valid_o.
  - ONE (1), accept & pop: stay ONE, H <= input.
  - ONE (1), accept & !pop: -> TWO, S <= input.
  - ONE (1), !accept & pop: -> EMPTY, H cleared.
  - ONE (1), neither: hold.
  - TWO (2), pop: -> ONE, H <= S, S cleared. No accept is possible because in_ready_o=0.
  - TWO (2), no pop: hold.
- Empty slots: always all-zero (data, reg, we), so outputs read 0 when out_valid_o=0.
- Non-writing entries: entries with reg_write=0 still occupy a slot and handshake normally; they only suppress reg_write_o and fwd_valid_o.
- Order: strict FIFO; no entry is lost or duplicated under any out_ready_i pattern.
- Invalid input: in_valid_i=0 with garbage payload must never be captured.

Decomposition:
- Shared package pipe_pkg holds:
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_IMM=2'b10, WB_SEL_ZERO=2'b11.
  - A packed struct wb_entry_t {valid, data[DATA_W], reg[RADDR_W], we}, reused by later stage registers.
- One natural sub-module: wb_src_mux, the combinational 4:1 select parametrised by DATA_W, also usable by the register-file write path.
- The skid logic stays inline.

Test Plan:
1. Reset, then alu=8'h3C, sel=00, reg=3, we=1, valid=1, out_ready=1 -> next cycle out_valid=1, wb_data=8'h3C, target=3, reg_write=1, fwd_valid=1; occupancy stays 1 under continuous streaming.
2. sel=01 mem=8'hA5, then sel=10 imm=8'h7F, then sel=11 -> wb_data shows A5, 7F, 00 on consecutive cycles.
3. out_ready=0, push entries E1=8'h11 and E2=8'h22 -> occupancy=2 and in_ready=0 after the second accept; a third valid input is not accepted. Release out_ready -> E1 then E2 in order, in_ready returns 1 one cycle after the first pop.
4. Occupancy=2, then flush_i=1 with in_valid=1 -> next cycle occupancy=0, all outputs 0, in_ready=1; the flushed-cycle input never appears.
5. Entry with we=0, data=8'hFF -> out_valid=1, reg_write=0, fwd_valid=0; handshake completes normally.
6. rst_n low mid-stream with occupancy=2 -> outputs clear without a clock edge; after release, behaviour matches scenario 1.
